serial_word_comparator: RTL and testbench
=========================================

# serial_word_comparator

Bit-serial magnitude comparator for two WIDTH-bit words, one bit pair per accepted cycle, producing registered greater/equal/less flags and a one-cycle `done` pulse at each word boundary. Generalises the single-stream sticky G/E/L comparator:

- Word length is parametrised.
- Bit order is selectable (MSB-first or LSB-first).
- Signed (two's complement) comparison is supported per word.
- Input may stall.
- An early-decision flag is provided.

It sits between the serial shift front-end and the lab's result/display logic.

## Interface
- `WIDTH`, default 8: bits per word; legal range ≥ 2.
- `MSB_FIRST`, default 1: 1 = first bit of each word is the MSB; 0 = first bit is the LSB.

- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `a` in 1: serial bit of operand A.
- `b` in 1: serial bit of operand B.
- `bit_valid` in 1: `a`/`b` carry a valid bit pair this cycle; low = stall, no state change.
- `signed_mode` in 1: 1 = two's-complement compare; sampled only with the first bit of a word.
- `G` out 1: last completed word had A > B.
- `E` out 1: last completed word had A == B.
- `L` out 1: last completed word had A < B.
- `done` out 1: one-cycle pulse; the flags were updated this cycle.
- `busy` out 1: a word is partially received.
- `decided` out 1: MSB-first only; result of the current word is already fixed.

## Operation
- State machine with two states.
  - IDLE: `bit_valid` = 1 accepts bit 0 of a new word, latches `signed_mode`, and moves to RUN (or straight to completion; WIDTH ≥ 2 makes that impossible).
  - RUN: each `bit_valid` = 1 accepts one bit pair. The WIDTH-th accepted bit completes the word and returns to IDLE.
- Bit counter runs 0..WIDTH-1 and is $clog2(WIDTH) bits wide. It clears to 0 at completion and does not wrap past WIDTH-1.
- Internal running result is one of EQ/GT/LT and starts at EQ for each word.
- MSB-first: the first differing bit decides and is then sticky. a=1, b=0 → GT.
  - Signed exception: if the first bit (the sign bit) differs, the decision is inverted (a=1, b=0 → LT).
- LSB-first: every differing bit overwrites the running result; equal bits retain it.
  - Signed exception: the final bit (the sign bit) uses the inverted rule.
- `decided` = 1 while in RUN with MSB_FIRST = 1 and running result ≠ EQ. Tied 0 when MSB_FIRST = 0.
- `G`/`E`/`L` are one-hot at all times. They change only on the completion edge and hold through the entire next word until its completion.
- `busy` = 1 exactly while in RUN.

## Timing
- Reset values:
  - State = IDLE, counter = 0, running result = EQ.
  - `G` = 0, `E` = 1, `L` = 0.
  - `done` = 0, `busy` = 0, `decided` = 0.
- Latency: flags and `done` are valid in the cycle after the edge that accepted the WIDTH-th bit. Throughput is one bit per cycle with no dead cycles.
- Back-to-back words:
  - The next word's first bit may be accepted in the cycle `done` is high.
  - Neither `done` nor the flags are disturbed by it.
  - `busy` goes high again the next cycle.
- Stalls: `bit_valid` = 0 freezes the counter, running result and state. A stall may occur at any bit position, including before the last bit.
- Reset mid-word:
  - Discards the partial word and returns all outputs to reset values on the next edge.
  - Reset takes priority over a simultaneous `bit_valid`.
- `signed_mode` changes mid-word are ignored.

## Structure
- Package `serial_cmp_pkg` contains:
  - state enum `{IDLE, RUN}`;
  - result enum `{RES_EQ, RES_GT, RES_LT}`;
  - a function mapping result to the one-hot `{G,E,L}`.
- Sub-module `serial_cmp_counter`: a WIDTH-parametrised bit counter.
  - Inputs: `clk`, `reset`, `en`, `clr`.
  - Outputs: `cnt`, `last` (`cnt` == WIDTH-1).
- All decision logic stays in the top module.

## Test plan
1. MSB_FIRST=1, unsigned, a=0xA5, b=0xA3, continuous `bit_valid` → `decided` rises after the 6th bit. After the 8th bit, `done` = 1 for one cycle and G=1, E=0, L=0.
2. MSB_FIRST=1, a=0x80, b=0x7F: with signed_mode=1 → L=1; repeated with signed_mode=0 → G=1. Flags hold between the two words.
3. MSB_FIRST=0, unsigned: a=0x01, b=0x80 → L=1. Then a=0x3C, b=0x3C → E=1 and `decided` is 0 throughout.
4. MSB_FIRST=0, signed: a=0xFF, b=0x01 → L=1. Then a=0x02, b=0xFE → G=1.
5. Random `bit_valid` gaps plus back-to-back words (new first bit in the `done` cycle), 200 random word pairs → exactly one `done` per 8 accepted bits, and every result matches the reference model.
6. Assert `reset` after 3 accepted bits with `bit_valid` = 1 → next cycle busy=0, G=0, E=1, L=0, done=0. The following full word compares correctly from count 0.

Source files
------------

// File: rtl/serial_cmp_pkg.sv
// Shared types for the bit-serial word comparator.
//   state_e    : word-assembly FSM state
//   res_e      : running comparison result
//   res_to_gel : maps a result to the one-hot {G,E,L} flag vector
package serial_cmp_pkg;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  typedef enum logic [1:0] {
    RES_EQ,
    RES_GT,
    RES_LT
  } res_e;

  // One-hot {G,E,L}; any non-GT/LT encoding reads as equal.
  function automatic logic [2:0] res_to_gel(input res_e r);
    case (r)
      RES_GT:  return 3'b100;
      RES_LT:  return 3'b001;
      default: return 3'b010;
    endcase
  endfunction

endpackage

// File: rtl/serial_cmp_counter.sv
// Bit-position counter for one serial word.
//   clk, reset : clock, synchronous active-high reset
//   en         : advance by one accepted bit
//   clr        : return to 0 (word complete); wins over en
//   cnt        : current bit position, 0..WIDTH-1
//   last       : cnt == WIDTH-1
module serial_cmp_counter #(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  logic [CNT_W-1:0] cnt_q;

  assign cnt  = cnt_q;
  assign last = (cnt_q == CNT_W'(WIDTH - 1));

  // Saturates at WIDTH-1 so a missing clr can never wrap into a bogus position.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt_q <= '0;
    end else if (en && !last) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/serial_word_comparator.sv
// Bit-serial magnitude comparator: one a/b bit pair per accepted cycle,
// registered one-hot G/E/L at each word boundary.
//   clk, reset   : clock, synchronous active-high reset
//   a, b         : serial operand bits
//   bit_valid    : a/b valid this cycle; low stalls everything
//   signed_mode  : two's-complement compare, sampled with a word's first bit
//   G, E, L      : result of the last completed word (one-hot)
//   done         : one-cycle pulse when G/E/L were just updated
//   busy         : a word is partially received
//   decided      : MSB-first only, the current word's result is already fixed
module serial_word_comparator
  import serial_cmp_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic a,
  input  logic b,
  input  logic bit_valid,
  input  logic signed_mode,
  output logic G,
  output logic E,
  output logic L,
  output logic done,
  output logic busy,
  output logic decided
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  state_e           state_q;
  res_e             res_q, res_d;
  logic             signed_q;
  logic [2:0]       gel_q;
  logic             done_q, busy_q, decided_q;
  logic [CNT_W-1:0] cnt_w;
  logic             last_w;

  logic first_c, sgn_c, sign_bit_c, gt_c;
  res_e base_c, bit_res_c;

  serial_cmp_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (bit_valid),
    .clr   (bit_valid && last_w),
    .cnt   (cnt_w),
    .last  (last_w)
  );

  // Result after folding in the current bit pair.
  always_comb begin
    first_c    = (state_q == IDLE);
    sgn_c      = first_c ? signed_mode : signed_q;
    // The sign bit arrives first in MSB-first order, last in LSB-first order.
    sign_bit_c = MSB_FIRST ? first_c : last_w;
    // A set sign bit makes the word smaller, so the per-bit verdict flips there.
    gt_c       = (a & ~b) ^ (sgn_c & sign_bit_c);
    bit_res_c  = gt_c ? RES_GT : RES_LT;
    base_c     = first_c ? RES_EQ : res_q;
    res_d      = base_c;
    // MSB-first: first difference is sticky. LSB-first: later differences dominate.
    if (a != b) begin
      if (!MSB_FIRST || (base_c == RES_EQ)) begin
        res_d = bit_res_c;
      end
    end
  end

  // Word FSM and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      res_q     <= RES_EQ;
      signed_q  <= 1'b0;
      gel_q     <= 3'b010;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      decided_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bit_valid) begin
        if (first_c) begin
          signed_q <= signed_mode;
        end
        if (last_w) begin
          state_q   <= IDLE;
          res_q     <= RES_EQ;
          gel_q     <= res_to_gel(res_d);
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          decided_q <= 1'b0;
        end else begin
          state_q   <= RUN;
          res_q     <= res_d;
          busy_q    <= 1'b1;
          decided_q <= MSB_FIRST && (res_d != RES_EQ);
        end
      end
    end
  end

  assign G       = gel_q[2];
  assign E       = gel_q[1];
  assign L       = gel_q[0];
  assign done    = done_q;
  assign busy    = busy_q;
  assign decided = decided_q;

endmodule

// File: tb/tb_serial_word_comparator.sv
// Directed and randomised bench for serial_word_comparator: one MSB-first and
// one LSB-first instance, each with its own bit_valid, sharing the rest.
module tb_serial_word_comparator;

  logic clk, reset, a, b, sm, vm, vl;
  logic gm, em, lm, dm, bm, decm;
  logic gl, el, ll, dl, bl, decl;

  int checks = 0;
  int errors = 0;
  int words_m = 0, words_l = 0;
  int done_cnt_m = 0, done_cnt_l = 0;
  logic [2:0] q_m[$];
  logic [2:0] q_l[$];

  serial_word_comparator #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(reset), .a(a), .b(b), .bit_valid(vm), .signed_mode(sm),
    .G(gm), .E(em), .L(lm), .done(dm), .busy(bm), .decided(decm)
  );

  serial_word_comparator #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .a(a), .b(b), .bit_valid(vl), .signed_mode(sm),
    .G(gl), .E(el), .L(ll), .done(dl), .busy(bl), .decided(decl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer compare of the two words.
  function automatic logic [2:0] model(input logic [7:0] x, input logic [7:0] y, input logic s);
    int xi, yi;
    if (s) begin
      xi = int'($signed(x));
      yi = int'($signed(y));
    end else begin
      xi = int'(x);
      yi = int'(y);
    end
    if (xi > yi) return 3'b100;
    if (xi < yi) return 3'b001;
    return 3'b010;
  endfunction

  // Sends one word to one instance. dec_at >= 0 checks decided after every bit
  // (expected high from bit dec_at onward, low after the last bit).
  task automatic send_word(input bit lsb, input logic [7:0] wa, input logic [7:0] wb,
                           input logic s, input bit gaps, input int dec_at,
                           input bit mid_chk, input logic [2:0] mid_exp);
    if (lsb) begin
      q_l.push_back(model(wa, wb, s));
      words_l++;
    end else begin
      q_m.push_back(model(wa, wb, s));
      words_m++;
    end
    for (int i = 0; i < 8; i++) begin
      int idx;
      idx = lsb ? i : 7 - i;
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      a  = wa[idx];
      b  = wb[idx];
      sm = (i == 0) ? s : 1'($urandom);
      if (lsb) vl = 1'b1; else vm = 1'b1;
      @(negedge clk);
      vm = 1'b0;
      vl = 1'b0;
      if (dec_at >= 0)
        chk("decided", 32'(lsb ? decl : decm), 32'((i < 7) && (i + 1 >= dec_at)));
      if (mid_chk && i == 3) begin
        chk("flags hold mid-word", 32'(lsb ? {gl, el, ll} : {gm, em, lm}), 32'(mid_exp));
        chk("busy mid-word", 32'(lsb ? bl : bm), 32'd1);
      end
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding word.
  always @(negedge clk) begin
    if (dm === 1'b1) begin
      done_cnt_m++;
      if (q_m.size() == 0) chk("spurious done msb", 32'(dm), 32'd0);
      else chk("flags msb", 32'({gm, em, lm}), 32'(q_m.pop_front()));
    end
    if (dl === 1'b1) begin
      done_cnt_l++;
      if (q_l.size() == 0) chk("spurious done lsb", 32'(dl), 32'd0);
      else chk("flags lsb", 32'({gl, el, ll}), 32'(q_l.pop_front()));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; a = 1'b0; b = 1'b0; sm = 1'b0; vm = 1'b0; vl = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset flags msb", 32'({gm, em, lm, dm, bm, decm}), 32'b010000);
    chk("reset flags lsb", 32'({gl, el, ll, dl, bl, decl}), 32'b010000);
    reset = 1'b0;
    @(negedge clk);

    // 1: MSB-first unsigned A5 vs A3, decided from bit 6.
    send_word(1'b0, 8'hA5, 8'hA3, 1'b0, 1'b0, 6, 1'b1, 3'b010);
    chk("t1 done", 32'(dm), 32'd1);
    chk("t1 flags", 32'({gm, em, lm}), 32'b100);
    chk("t1 busy after word", 32'(bm), 32'd0);
    @(negedge clk);
    chk("t1 done pulse width", 32'(dm), 32'd0);
    chk("t1 flags held", 32'({gm, em, lm}), 32'b100);

    // 2: 80 vs 7F signed then unsigned, flags held into the second word.
    send_word(1'b0, 8'h80, 8'h7F, 1'b1, 1'b0, 1, 1'b1, 3'b100);
    chk("t2 signed", 32'({gm, em, lm}), 32'b001);
    send_word(1'b0, 8'h80, 8'h7F, 1'b0, 1'b0, 1, 1'b1, 3'b001);
    chk("t2 unsigned", 32'({gm, em, lm}), 32'b100);
    chk("t2 done", 32'(dm), 32'd1);

    // 3: LSB-first unsigned; decided stays low.
    send_word(1'b1, 8'h01, 8'h80, 1'b0, 1'b0, 100, 1'b0, 3'b000);
    chk("t3 lt", 32'({gl, el, ll}), 32'b001);
    send_word(1'b1, 8'h3C, 8'h3C, 1'b0, 1'b0, 100, 1'b1, 3'b001);
    chk("t3 eq", 32'({gl, el, ll}), 32'b010);
    chk("t3 done", 32'(dl), 32'd1);

    // 4: LSB-first signed.
    send_word(1'b1, 8'hFF, 8'h01, 1'b1, 1'b0, 100, 1'b0, 3'b000);
    chk("t4 lt", 32'({gl, el, ll}), 32'b001);
    send_word(1'b1, 8'h02, 8'hFE, 1'b1, 1'b0, 100, 1'b0, 3'b000);
    chk("t4 gt", 32'({gl, el, ll}), 32'b100);

    // 5: random words, random gaps, back-to-back where no gap is drawn.
    for (int n = 0; n < 200; n++)
      send_word(1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1, -1, 1'b0, 3'b000);
    for (int n = 0; n < 40; n++)
      send_word(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1, -1, 1'b0, 3'b000);
    repeat (2) @(negedge clk);
    chk("done count msb", 32'(done_cnt_m), 32'(words_m));
    chk("done count lsb", 32'(done_cnt_l), 32'(words_l));
    chk("queue drained msb", 32'(q_m.size()), 32'd0);

    // 6: reset after three accepted bits, with bit_valid high alongside reset.
    send_word(1'b0, 8'h90, 8'h10, 1'b0, 1'b0, -1, 1'b0, 3'b000);
    chk("t6 pre flags", 32'({gm, em, lm}), 32'b100);
    for (int i = 0; i < 3; i++) begin
      a = 1'b1; b = 1'b0; sm = 1'b0; vm = 1'b1;
      @(negedge clk);
      vm = 1'b0;
    end
    chk("t6 partial busy/decided", 32'({bm, decm}), 32'b11);
    reset = 1'b1; vm = 1'b1; a = 1'b1; b = 1'b1;
    @(negedge clk);
    chk("t6 reset msb", 32'({gm, em, lm, dm, bm, decm}), 32'b010000);
    chk("t6 reset lsb", 32'({gl, el, ll, dl, bl, decl}), 32'b010000);
    reset = 1'b0; vm = 1'b0;
    send_word(1'b0, 8'h12, 8'h34, 1'b0, 1'b0, 3, 1'b1, 3'b010);
    chk("t6 after reset", 32'({gm, em, lm}), 32'b001);
    chk("t6 done", 32'(dm), 32'd1);
    @(negedge clk);
    chk("final done count msb", 32'(done_cnt_m), 32'(words_m));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
